alu_seq: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle datapath ALU, for the RISC core execute stage.
- Keeps the existing 4-bit opcode map.
- Generalises operand width.
- Shifts use the full shift amount, not just bit 0, one bit per cycle.
- Adds an iterative shift-add multiply.
- Uses a valid/ready handshake on both sides so the core can stall on long operations.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_seq_comb.sv | 36 +++
 rtl/alu_seq.sv | 136 +++++++++++++
 tb/tb_alu_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode map and FSM state encoding shared by alu_seq and alu_seq_comb
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_ASL  = 4'h6;
  localparam logic [3:0] OP_LSL  = 4'h7;
  localparam logic [3:0] OP_ASR  = 4'h8;
  localparam logic [3:0] OP_LSR  = 4'h9;
  localparam logic [3:0] OP_ADD4 = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;
  function automatic logic is_shift(input logic [3:0] op);
    return op inside {OP_ASL, OP_LSL, OP_ASR, OP_LSR};
  endfunction
endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: single-cycle ops (add/sub/and/xor/or/not/a+4b); other opcodes pass a through
// Carry/overflow outputs exist only with ALU_SEQ_FLAGS_EN.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] y
`ifdef ALU_SEQ_FLAGS_EN
  ,output logic            c
  ,output logic            v
`endif
);
  logic [WIDTH-1:0] opb, sum;
  logic cin, arith;
  // sub and a+(b<<2) share the adder with add
  assign opb = alu_sel == OP_SUB ? ~b : alu_sel == OP_ADD4 ? b << 2 : b;
  assign cin = alu_sel == OP_SUB;
  assign arith = alu_sel inside {OP_ADD, OP_SUB, OP_ADD4};
`ifdef ALU_SEQ_FLAGS_EN
  logic cout;
  assign {cout, sum} = {1'b0, a} + {1'b0, opb} + (WIDTH+1)'(cin);
  assign c = arith & cout;
  assign v = (alu_sel == OP_ADD || alu_sel == OP_SUB) & (a[WIDTH-1] == opb[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
`else
  assign sum = a + opb + WIDTH'(cin);
`endif
  assign y = arith ? sum :
             alu_sel == OP_AND ? a & b :
             alu_sel == OP_XOR ? a ^ b :
             alu_sel == OP_OR  ? a | b :
             alu_sel == OP_NOT ? ~a : a;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU, 1-bit/cycle shifter and shift-add multiplier behind valid/ready
// Optional Z/C/V flag outputs with ALU_SEQ_FLAGS_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef ALU_SEQ_FLAGS_EN
  ,output logic            flag_z
  ,output logic            flag_c
  ,output logic            flag_v
`endif
);
  state_t state_q, state_d;
  logic [SHW:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d, mplier_q, mplier_d, acc_q, acc_d, res_q, res_d;
  logic [WIDTH-1:0] comb_y, sh, acc_n;
  logic [SHW-1:0] amt;
`ifdef ALU_SEQ_FLAGS_EN
  logic cf, vf, z_q, z_d, c_q, c_d, v_q, v_d;
  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (.a(a), .b(b), .alu_sel(alu_sel), .y(comb_y), .c(cf), .v(vf));
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
`else
  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (.a(a), .b(b), .alu_sel(alu_sel), .y(comb_y));
`endif
  assign amt = b[SHW-1:0];
  assign in_ready = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign result = res_q;
  // work_q is the shift operand in SHIFT and the multiplicand in MUL
  assign sh = op_q == OP_ASR ? {work_q[WIDTH-1], work_q[WIDTH-1:1]} :
              op_q == OP_LSR ? {1'b0, work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
  assign acc_n = mplier_q[0] ? acc_q + work_q : acc_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    work_d = work_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    res_d = res_q;
`ifdef ALU_SEQ_FLAGS_EN
    z_d = z_q;
    c_d = c_q;
    v_d = v_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d = alu_sel;
        work_d = a;
        mplier_d = b;
        acc_d = '0;
`ifdef ALU_SEQ_FLAGS_EN
        c_d = cf;
        v_d = vf;
`endif
        if (alu_sel == OP_MUL) begin
          state_d = S_MUL;
          cnt_d = (SHW+1)'(WIDTH);
        end else if (is_shift(alu_sel) && amt != '0) begin
          state_d = S_SHIFT;
          cnt_d = {1'b0, amt};
        end else begin
          state_d = S_DONE;
          res_d = is_shift(alu_sel) ? a : comb_y;
        end
      end
      S_SHIFT: begin
        work_d = sh;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1)) begin
          state_d = S_DONE;
          res_d = sh;
        end
      end
      S_MUL: begin
        acc_d = acc_n;
        work_d = work_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1)) begin
          state_d = S_DONE;
          res_d = acc_n;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef ALU_SEQ_FLAGS_EN
    if (state_d == S_DONE && state_q != S_DONE) z_d = res_d == '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      op_q <= '0;
      work_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      res_q <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      work_q <= work_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      res_q <= res_d;
`ifdef ALU_SEQ_FLAGS_EN
      z_q <= z_d;
      c_q <= c_d;
      v_q <= v_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized scoreboard bench for alu_seq (WIDTH=32); flag checks with ALU_SEQ_FLAGS_EN
module tb_alu_seq;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0] alu_sel;
`ifdef ALU_SEQ_FLAGS_EN
  logic flag_z, flag_c, flag_v;
`endif
  typedef struct {
    logic [31:0] r;
    logic z, c, v;
    int acc;
    int ready_at;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, hold = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef ALU_SEQ_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic ovf(input longint s);
    return s > 64'sd2147483647 || s < -64'sd2147483648;
  endfunction

  // Reference: plain wide arithmetic; latency = shift amount or 32 for mul
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input int acc);
    exp_t e;
    longint sx = longint'($signed(x)), sy = longint'($signed(y));
    logic [63:0] ux = {32'b0, x}, uy = {32'b0, y};
    int k = int'(y[4:0]);
    int lat = 0;
    e.c = 0;
    e.v = 0;
    case (op)
      4'd0: begin e.r = x + y; e.c = (ux + uy) > 64'hFFFFFFFF; e.v = ovf(sx + sy); end
      4'd1: begin e.r = x - y; e.c = x >= y; e.v = ovf(sx - sy); end
      4'd2: e.r = x & y;
      4'd3: e.r = x ^ y;
      4'd4: e.r = x | y;
      4'd5: e.r = ~x;
      4'd6, 4'd7: begin e.r = x << k; lat = k; end
      4'd8: begin e.r = $signed(x) >>> k; lat = k; end
      4'd9: begin e.r = x >> k; lat = k; end
      4'd10: begin e.r = x + y * 4; e.c = (ux + uy * 4) > 64'hFFFFFFFF; end
      4'd11: begin e.r = x * y; lat = 32; end
      default: e.r = x;
    endcase
    e.z = e.r == 0;
    e.acc = acc;
    e.ready_at = acc + lat;
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      return;
    end
    alu_sel = op;
    a = av;
    b = bv;
    in_valid = 1;
    sb.push_back(model(op, av, bv, cyc + 1));
    @(negedge clk);
    // garbage while busy must be ignored
    in_valid = 1'($urandom_range(0, 1));
    a = $urandom;
    b = $urandom;
    alu_sel = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    in_valid = 0;
    while ((sb.size() > 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int wait_n = 0;
    bit seen = 0, expect_low = 0;
    out_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (expect_low) begin
        chk("valid_drop", out_valid, 0);
        expect_low = 0;
      end
      if (out_valid) begin
        wait_n = 0;
        if (sb.size() == 0) begin
          chk("spurious_valid", out_valid, 0);
          out_ready = 1;
        end else begin
          if (!seen) begin
            chk("latency", cyc, sb[0].ready_at);
            seen = 1;
          end
          chk("result", result, sb[0].r);
          chk("in_ready_done", in_ready, 0);
`ifdef ALU_SEQ_FLAGS_EN
          chk("flags", {flag_z, flag_c, flag_v}, {sb[0].z, sb[0].c, sb[0].v});
`endif
          out_ready = hold > 0 ? 1'b0 : ($urandom_range(0, 3) != 0);
          if (hold > 0) hold--;
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
            expect_low = 1;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        if (sb.size() > 0 && cyc >= sb[0].acc) begin
          chk("in_ready_busy", in_ready, 0);
          if (++wait_n > 100) begin
            chk("result_timeout", out_valid, 1);
            sb.delete();
            seen = 0;
            wait_n = 0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1;
    in_valid = 0;
    a = 0;
    b = 0;
    alu_sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    rst = 0;
    issue(4'h0, 32'h7FFFFFFF, 32'd1);
    issue(4'h8, 32'h80000010, 32'd4);
    issue(4'hB, 32'hFFFFFFFD, 32'd7);
    issue(4'h7, 32'd1, 32'h20);
    issue(4'h7, 32'd1, 32'd31);
    wait_idle();
    hold = 5;
    issue(4'h1, 32'd10, 32'd3);
    issue(4'h0, 32'd5, 32'd6);
    for (int i = 0; i < 150; i++) issue(4'($urandom_range(0, 15)), $urandom, $urandom);
    wait_idle();
    issue(4'hB, $urandom, $urandom);
    repeat (9) @(negedge clk);
    in_valid = 0;
    rst = 1;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst = 0;
    issue(4'h0, 32'd2, 32'd2);
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
